// File: rtl/pc_sequencer.sv
// Fetch sequencer: drives the external PC register, runs the imem fetch
// handshake, branch select, halt/resume, fetch watchdog and retire counter.
module pc_sequencer #(
  parameter int              ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              TIMEOUT   = 16,
  parameter int              CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_load,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  input  logic              resume,
  output logic              fetch_err,
  output logic              busy,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]   WD_ONE  = WD_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2,
    HALT   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    wd_d      = '0;
    pc_load   = 1'b0;
    pc_next   = pc_cur;
    fetch_req = 1'b0;
    unique case (state_q)
      BOOT: begin
        pc_load = 1'b1;
        pc_next = RESET_VEC;
        state_d = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        // an ack on the final watchdog cycle still wins
        if (fetch_ack) begin
          state_d = UPDATE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      UPDATE: begin
        pc_load = 1'b1;
        pc_next = branch_taken ? branch_target : pc_cur + PC_ONE;
        cnt_d   = cnt_q + CNT_ONE;
        state_d = halt ? HALT : FETCH;
      end
      HALT: begin
        if (resume) begin
          state_d = FETCH;
          err_d   = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign fetch_addr  = pc_cur;
  assign fetch_err   = err_q;
  assign busy        = (state_q != HALT);
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with an external PC register model
// and a PC/retire-count reference computed from the fetch rules.
module tb_pc_sequencer;

  localparam int AW = 20;
  localparam int CW = 32;
  localparam logic [AW-1:0] MASK = {AW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc_cur;
  logic [AW-1:0] pc_next;
  logic          pc_load;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ack;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          halt;
  logic          resume;
  logic          fetch_err;
  logic          busy;
  logic [1:0]    state;
  logic [CW-1:0] instr_count;

  int tests = 0;
  int fails = 0;
  logic [AW-1:0] exp_pc;
  logic [CW-1:0] exp_cnt;

  pc_sequencer #(
    .ADDR_W(AW), .RESET_VEC(20'h00000), .TIMEOUT(16), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_next(pc_next),
    .pc_load(pc_load), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt), .resume(resume),
    .fetch_err(fetch_err), .busy(busy), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pc_load) pc_cur <= pc_next;

  task automatic cyc();
    @(negedge clk);
  endtask

  // drives one instruction starting at a FETCH negedge; returns observations
  task automatic do_instr(input int dly, input bit tk,
                          input logic [AW-1:0] tgt, input bit hl,
                          output logic [AW-1:0] fa,
                          output logic [AW-1:0] pn,
                          output int reqs, output bit upd_ok);
    reqs = 0;
    for (int i = 0; i < dly; i++) begin
      fetch_ack = 1'b0;
      #1;
      if (fetch_req) reqs++;
      cyc();
    end
    fetch_ack = 1'b1;
    #1;
    if (fetch_req) reqs++;
    fa = fetch_addr;
    cyc();
    fetch_ack = 1'b0;
    branch_taken = tk;
    branch_target = tgt;
    halt = hl;
    #1;
    pn = pc_next;
    upd_ok = (state == 2'd2) && pc_load;
    cyc();
    branch_taken = 1'b0;
    branch_target = $urandom;
    halt = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW-1:0] fa, pn;
    int r;
    bit u;
    rst_n = 1'b0;
    cyc();
    cyc();
    #1;
    tests++;
    if (state !== 2'd0 || pc_load !== 1'b1 || pc_next !== 20'h0) begin
      fails++;
      $display("FAIL reset_boot state=%0d load=%b next=%h want 0 1 0",
               state, pc_load, pc_next);
    end
    tests++;
    if (instr_count !== 0 || fetch_err !== 1'b0 || fetch_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs cnt=%0d err=%b req=%b want 0 0 0",
               instr_count, fetch_err, fetch_req);
    end
    rst_n = 1'b1;
    cyc();
    exp_pc = 20'h0;
    exp_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      do_instr(0, 1'b0, 20'h0, 1'b0, fa, pn, r, u);
      tests++;
      if (fa !== exp_pc || pn !== exp_pc + 1 || !u) begin
        fails++;
        $display("FAIL boot_seq%0d fa=%h pn=%h upd=%b want %h %h 1",
                 k, fa, pn, u, exp_pc, exp_pc + 1);
      end
      exp_pc = exp_pc + 1;
      exp_cnt++;
    end
    #1;
    tests++;
    if (fetch_addr !== 20'h3 || instr_count !== 3 || fetch_req !== 1'b1) begin
      fails++;
      $display("FAIL boot_cnt fa=%h cnt=%0d req=%b want 3 3 1",
               fetch_addr, instr_count, fetch_req);
    end
  endtask

  task automatic test_branch();
    logic [AW-1:0] fa, pn;
    int r;
    bit u;
    do_instr(1, 1'b0, 20'h0, 1'b0, fa, pn, r, u);
    do_instr(0, 1'b0, 20'h0, 1'b0, fa, pn, r, u);
    exp_cnt += 2;
    do_instr(0, 1'b1, 20'h0A000, 1'b0, fa, pn, r, u);
    exp_cnt++;
    tests++;
    if (fa !== 20'h5 || pn !== 20'h0A000) begin
      fails++;
      $display("FAIL branch fa=%h pn=%h want 00005 0a000", fa, pn);
    end
    #1;
    tests++;
    if (fetch_addr !== 20'h0A000 || instr_count !== exp_cnt) begin
      fails++;
      $display("FAIL branch_next fa=%h cnt=%0d want 0a000 %0d",
               fetch_addr, instr_count, exp_cnt);
    end
  endtask

  task automatic test_wrap_stall();
    logic [AW-1:0] fa, pn;
    int r;
    bit u;
    do_instr(0, 1'b1, 20'hFFFFF, 1'b0, fa, pn, r, u);
    do_instr(5, 1'b0, 20'h0, 1'b0, fa, pn, r, u);
    exp_cnt += 2;
    tests++;
    if (r != 6 || pn !== 20'h00000 || fa !== 20'hFFFFF) begin
      fails++;
      $display("FAIL wrap_stall reqs=%0d pn=%h fa=%h want 6 00000 fffff",
               r, pn, fa);
    end
    #1;
    tests++;
    if (fetch_err !== 1'b0 || fetch_addr !== 20'h0) begin
      fails++;
      $display("FAIL wrap_next err=%b fa=%h want 0 00000",
               fetch_err, fetch_addr);
    end
    do_instr(15, 1'b0, 20'h0, 1'b0, fa, pn, r, u);
    exp_cnt++;
    #1;
    tests++;
    if (r != 16 || fetch_err !== 1'b0 || state !== 2'd1 || pc_cur !== 20'h1) begin
      fails++;
      $display("FAIL ack_at_timeout reqs=%0d err=%b st=%0d pc=%h want 16 0 1 1",
               r, fetch_err, state, pc_cur);
    end
  endtask

  task automatic test_watchdog();
    logic [AW-1:0] pc0;
    pc0 = pc_cur;
    fetch_ack = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    #1;
    tests++;
    if (state !== 2'd1 || fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL wd_early st=%0d err=%b want 1 0", state, fetch_err);
    end
    cyc();
    #1;
    tests++;
    if (state !== 2'd3 || fetch_err !== 1'b1 || busy !== 1'b0 ||
        fetch_req !== 1'b0 || pc_cur !== pc0) begin
      fails++;
      $display("FAIL wd_trip st=%0d err=%b busy=%b req=%b pc=%h want 3 1 0 0 %h",
               state, fetch_err, busy, fetch_req, pc_cur, pc0);
    end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    #1;
    tests++;
    if (state !== 2'd1 || fetch_err !== 1'b0 || fetch_addr !== pc0) begin
      fails++;
      $display("FAIL wd_resume st=%0d err=%b fa=%h want 1 0 %h",
               state, fetch_err, fetch_addr, pc0);
    end
  endtask

  task automatic test_halt();
    logic [AW-1:0] fa, pn;
    int r;
    bit u;
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    #1;
    tests++;
    if (state !== 2'd1) begin
      fails++;
      $display("FAIL halt_in_fetch st=%0d want 1", state);
    end
    do_instr(0, 1'b1, 20'h7, 1'b0, fa, pn, r, u);
    do_instr(0, 1'b0, 20'h0, 1'b1, fa, pn, r, u);
    exp_cnt += 2;
    cyc();
    #1;
    tests++;
    if (pn !== 20'h8 || pc_cur !== 20'h8 || state !== 2'd3 || busy !== 1'b0) begin
      fails++;
      $display("FAIL halt pn=%h pc=%h st=%0d busy=%b want 8 8 3 0",
               pn, pc_cur, state, busy);
    end
    halt = 1'b1;
    resume = 1'b1;
    cyc();
    halt = 1'b0;
    resume = 1'b0;
    #1;
    tests++;
    if (state !== 2'd1 || fetch_addr !== 20'h8 || instr_count !== exp_cnt) begin
      fails++;
      $display("FAIL halt_resume st=%0d fa=%h cnt=%0d want 1 8 %0d",
               state, fetch_addr, instr_count, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] fa, pn, want;
    int r, d, hw;
    bit tk, hl, u;
    logic [AW-1:0] tgt;
    exp_pc = pc_cur;
    for (int n = 0; n < 40; n++) begin
      d = $urandom_range(0, 6);
      tk = $urandom_range(0, 2) == 0;
      tgt = AW'($urandom) & MASK;
      hl = $urandom_range(0, 5) == 0;
      want = tk ? tgt : (exp_pc + 1) & MASK;
      do_instr(d, tk, tgt, hl, fa, pn, r, u);
      exp_cnt++;
      tests++;
      if (fa !== exp_pc || pn !== want || r != d + 1 || !u) begin
        fails++;
        $display("FAIL rand%0d fa=%h pn=%h reqs=%0d upd=%b want %h %h %0d 1",
                 n, fa, pn, r, u, exp_pc, want, d + 1);
      end
      exp_pc = want;
      if (hl) begin
        hw = $urandom_range(0, 3);
        for (int i = 0; i < hw; i++) cyc();
        #1;
        tests++;
        if (state !== 2'd3 || busy !== 1'b0 || pc_load !== 1'b0) begin
          fails++;
          $display("FAIL rand_halt%0d st=%0d busy=%b load=%b want 3 0 0",
                   n, state, busy, pc_load);
        end
        resume = 1'b1;
        cyc();
        resume = 1'b0;
      end
    end
    #1;
    tests++;
    if (instr_count !== exp_cnt || fetch_addr !== exp_pc) begin
      fails++;
      $display("FAIL rand_end cnt=%0d fa=%h want %0d %h",
               instr_count, fetch_addr, exp_cnt, exp_pc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    fetch_ack = 1'b0;
    cyc();
    rst_n = 1'b0;
    fetch_ack = 1'b1;
    cyc();
    fetch_ack = 1'b0;
    #1;
    tests++;
    if (state !== 2'd0 || instr_count !== 0 || pc_load !== 1'b1 ||
        pc_next !== 20'h0) begin
      fails++;
      $display("FAIL rst_mid st=%0d cnt=%0d load=%b next=%h want 0 0 1 0",
               state, instr_count, pc_load, pc_next);
    end
    rst_n = 1'b1;
    cyc();
    #1;
    tests++;
    if (state !== 2'd1 || fetch_addr !== 20'h0 || fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_boot st=%0d fa=%h err=%b want 1 0 0",
               state, fetch_addr, fetch_err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_ack = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    halt = 1'b0;
    resume = 1'b0;
    cyc();
    test_reset();
    test_branch();
    test_wrap_stall();
    test_watchdog();
    test_halt();
    test_random();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch sequencer that drives the 20-bit program-counter register. It generates the PC register's load-data and load-enable (pc_next, pc_load) and reads back its output (pc_cur). It also runs the instruction-memory fetch handshake, selects increment versus branch, and supports halt/resume. A fetch watchdog and a retired-instruction counter are included.

Parameters:
ADDR_W, 20, PC / fetch address width
RESET_VEC, 20'h00000, PC value loaded after reset
TIMEOUT, 16, max cycles in FETCH without fetch_ack before error
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
pc_cur  in  ADDR_W  current PC register output
pc_next  out  ADDR_W  load data to PC register
pc_load  out  1  load enable to PC register
fetch_req  out  1  fetch request to instruction memory
fetch_addr  out  ADDR_W  fetch address
fetch_ack  in  1  instruction returned, one-cycle pulse
branch_taken  in  1  take branch for current instruction
branch_target  in  ADDR_W  branch destination
halt  in  1  stop at next instruction boundary
resume  in  1  leave HALT
fetch_err  out  1  sticky watchdog error
busy  out  1  state != HALT
state  out  2  BOOT=0, FETCH=1, UPDATE=2, HALT=3
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset: one clock and a synchronous, active-low reset (rst_n). Sampled low at a rising edge, it sets:
  - state=BOOT, fetch_err=0, instr_count=0, watchdog=0.
  - All outputs take their BOOT values on the next cycle.
- Reset mid-operation (any state, including FETCH awaiting ack) aborts the fetch with no PC load. A late fetch_ack is ignored.
- BOOT (1 cycle): pc_load=1, pc_next=RESET_VEC, fetch_req=0. Next state is FETCH, and pc_cur=RESET_VEC on entry to FETCH.
- FETCH:
  - Outputs: fetch_req=1, fetch_addr=pc_cur, pc_load=0.
  - fetch_ack=1 at an edge: go to UPDATE and clear the watchdog.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 with no ack: set fetch_err=1, go to HALT, no load.
  - A fetch_ack in the same cycle as the timeout wins; no error.
- UPDATE (exactly 1 cycle):
  - Load: pc_load=1; pc_next = branch_taken ? branch_target : pc_cur+1. Branch inputs are sampled combinationally in this cycle only.
  - Increment is modulo 2^ADDR_W: 20'hFFFFF wraps to 20'h00000.
  - instr_count increments, wrapping modulo 2^CNT_W.
  - Next state is HALT if halt=1, else FETCH. The PC load still occurs on entry to HALT, so resume continues at the correct address.
- HALT:
  - Outputs: fetch_req=0, pc_load=0, busy=0.
  - resume=1: go to FETCH and clear fetch_err.
  - halt and resume both high in HALT: resume wins.
  - halt is ignored in BOOT and FETCH; it takes effect only at an UPDATE boundary.
- Defaults:
  - pc_next=pc_cur whenever pc_load=0.
  - fetch_addr=pc_cur in all states; it is qualified only by fetch_req.
  - branch inputs are don't-care outside UPDATE.
- Timing: fetch_req, pc_load, pc_next, fetch_addr and busy decode combinationally from state and inputs. state, fetch_err, instr_count and the watchdog are registers.
- Latency: with fetch_ack in the first FETCH cycle, one instruction takes 2 cycles (FETCH, UPDATE). The new PC is visible on pc_cur in the following FETCH cycle.

Test Plan:
1. Reset and boot: rst_n low 2 cycles, then high; ack every fetch.
   -> BOOT with pc_load=1, pc_next=0; then fetch_addr sequence 0,1,2,3; instr_count=3 after third UPDATE.
2. Branch: at pc=5, branch_taken=1, target=20'h0A000 in UPDATE.
   -> pc_next=20'h0A000; next fetch_addr=20'h0A000; instr_count +1.
3. Wrap and stall: preload pc=20'hFFFFF; hold fetch_ack low 5 cycles, then pulse.
   -> fetch_req high 6 cycles; no error; pc_next=20'h00000.
4. Watchdog: no fetch_ack for 16 cycles (TIMEOUT=16).
   -> fetch_err=1; state=HALT; pc unchanged.
   -> resume=1 clears fetch_err and returns to FETCH at the same address.
5. Halt and resume: halt=1 during UPDATE at pc=7.
   -> pc loaded to 8, state=HALT, busy=0.
   -> halt+resume together gives FETCH with fetch_addr=8.
6. Reset mid-FETCH: rst_n low while fetch_req=1, fetch_ack arrives same cycle.
   -> ack ignored; BOOT; instr_count=0; pc reloads RESET_VEC.
